// File: rtl/cpu_sram_arbiter_if.sv
// Bundle of the arbiter's buses: instruction master, data master, shared SRAM-like slave.
// 'slave' is the arbiter's own view; 'master' is the view of the surrounding core/bridge.
interface cpu_sram_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    logic        resp_err;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata,
        output resp_err
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata,
        input  resp_err
    );
endinterface

// File: rtl/cpu_sram_arbiter.sv
// Merges instruction and data SRAM-like masters onto one slave port; an owner FIFO routes responses.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed data priority.
module cpu_sram_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int PTR_W           = 2
) (
    input  logic               clk,
    input  logic               reset,
    cpu_sram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOCK_I,
        LOCK_D
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

    state_t                     state;
    state_t                     next_state;
    logic [PTR_W:0]             count;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [MAX_OUTSTANDING-1:0] owner_q;   // 1 = data master, 0 = inst master
    logic                       resp_err_q;

    logic grant_i;
    logic grant_d;
    logic full;
    logic pick_data;
    logic accept;
    logic pop;
    logic head_is_data;

    assign full = (count == FULL_CNT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;   // 1 = data was granted last, 0 = inst

    // On contention the master that did not win last time goes first.
    assign pick_data = bus.data_req && (!bus.inst_req || !last_grant);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b0;
        else if (accept)
            last_grant <= grant_d;
    end
`else
    assign pick_data = bus.data_req;
`endif

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!full) begin
                        if (pick_data) begin
                            grant_d = 1'b1;
                            if (!bus.sram_addr_ok)
                                next_state = LOCK_D;
                        end else if (bus.inst_req) begin
                            grant_i = 1'b1;
                            if (!bus.sram_addr_ok)
                                next_state = LOCK_I;
                        end
                    end
                end
                // A locked grant ignores the other master so the slave request stays stable.
                LOCK_I: begin
                    grant_i = 1'b1;
                    if (bus.sram_addr_ok)
                        next_state = IDLE;
                end
                LOCK_D: begin
                    grant_d = 1'b1;
                    if (bus.sram_addr_ok)
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.sram_req   = 1'b0;
        bus.sram_wr    = 1'b0;
        bus.sram_size  = 2'd0;
        bus.sram_addr  = 32'd0;
        bus.sram_wstrb = 4'd0;
        bus.sram_wdata = 32'd0;
        if (grant_d) begin
            bus.sram_req   = bus.data_req;
            bus.sram_wr    = bus.data_wr;
            bus.sram_size  = bus.data_size;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wstrb = bus.data_wstrb;
            bus.sram_wdata = bus.data_wdata;
        end else if (grant_i) begin
            bus.sram_req   = bus.inst_req;
            bus.sram_wr    = bus.inst_wr;
            bus.sram_size  = bus.inst_size;
            bus.sram_addr  = bus.inst_addr;
            bus.sram_wstrb = bus.inst_wstrb;
            bus.sram_wdata = bus.inst_wdata;
        end
    end

    assign accept           = bus.sram_req && bus.sram_addr_ok;
    assign bus.inst_addr_ok = accept && grant_i;
    assign bus.data_addr_ok = accept && grant_d;

    assign pop              = bus.sram_data_ok && (count != '0) && !reset;
    assign head_is_data     = owner_q[rd_ptr];
    assign bus.inst_data_ok = pop && !head_is_data;
    assign bus.data_data_ok = pop && head_is_data;
    assign bus.inst_rdata   = bus.sram_rdata;
    assign bus.data_rdata   = bus.sram_rdata;
    assign bus.resp_err     = resp_err_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.sram_data_ok && (count == '0))
                resp_err_q <= 1'b1;
        end
    end

    // NOTE: the owner storage is not reset; count and pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept)
            owner_q[wr_ptr] <= grant_d;
    end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Directed, table-driven bench for cpu_sram_arbiter: grant priority, locking, response
// steering, FIFO full/wrap, orphan-response flag and reset.
module tb_cpu_sram_arbiter;

    typedef struct {
        logic        ir;
        logic        dr;
        logic [31:0] ia;
        logic [31:0] da;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_sreq;
        logic        e_gd;
        logic [31:0] e_saddr;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
        logic        e_err;
    } vec_t;

    localparam logic [31:0] I_WDATA = 32'h1111_1111;
    localparam logic [31:0] D_WDATA = 32'h2222_2222;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    cpu_sram_arbiter_if bus ();

    cpu_sram_arbiter #(
        .MAX_OUTSTANDING(4),
        .PTR_W          (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic ir, input logic dr, input logic [31:0] ia, input logic [31:0] da,
        input logic aok, input logic dok, input logic [31:0] rd,
        input logic es, input logic egd, input logic [31:0] esa,
        input logic eia, input logic eda, input logic eid, input logic edd, input logic eerr);
        vec_t v;
        v.ir = ir; v.dr = dr; v.ia = ia; v.da = da; v.aok = aok; v.dok = dok; v.rd = rd;
        v.e_sreq = es; v.e_gd = egd; v.e_saddr = esa;
        v.e_iaok = eia; v.e_daok = eda; v.e_idok = eid; v.e_ddok = edd; v.e_err = eerr;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic dr, input logic [31:0] ia,
                         input logic [31:0] da, input logic aok, input logic dok,
                         input logic [31:0] rd);
        bus.inst_req     = ir;
        bus.data_req     = dr;
        bus.inst_addr    = ia;
        bus.data_addr    = da;
        bus.sram_addr_ok = aok;
        bus.sram_data_ok = dok;
        bus.sram_rdata   = rd;
    endtask

    initial begin
        bus.inst_wr    = 1'b0;
        bus.inst_size  = 2'd2;
        bus.inst_wstrb = 4'h0;
        bus.inst_wdata = I_WDATA;
        bus.data_wr    = 1'b1;
        bus.data_size  = 2'd1;
        bus.data_wstrb = 4'hF;
        bus.data_wdata = D_WDATA;

        // Test 1: contention in IDLE, then drain (owner order D, I)
        vecs.push_back(mk(1,1,32'hBFC0_0000,32'h1000,1,0,0,      1,1,32'h1000,     0,1,0,0,0));
        vecs.push_back(mk(1,0,32'hBFC0_0000,0,1,0,0,             1,0,32'hBFC0_0000,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'hA1,                    0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'hA2,                    0,0,0,0,0,1,0,0));
        // Test 2: inst locked for 3 cycles while data arrives
        vecs.push_back(mk(1,0,32'hBFC0_0004,0,0,0,0,             1,0,32'hBFC0_0004,0,0,0,0,0));
        vecs.push_back(mk(1,1,32'hBFC0_0004,32'h2000,0,0,0,      1,0,32'hBFC0_0004,0,0,0,0,0));
        vecs.push_back(mk(1,1,32'hBFC0_0004,32'h2000,0,0,0,      1,0,32'hBFC0_0004,0,0,0,0,0));
        vecs.push_back(mk(1,1,32'hBFC0_0004,32'h2000,1,0,0,      1,0,32'hBFC0_0004,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h2000,1,0,0,                  1,1,32'h2000,     0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h5,                     0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h6,                     0,0,0,0,0,0,1,0));
        // Test 3: I, D, I accepted then responses 0x11/0x22/0x33
        vecs.push_back(mk(1,0,32'h100,0,1,0,0,                   1,0,32'h100,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,32'h200,1,0,0,                   1,1,32'h200,0,1,0,0,0));
        vecs.push_back(mk(1,0,32'h104,0,1,0,0,                   1,0,32'h104,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h11,                    0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h22,                    0,0,0,0,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h33,                    0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0));
        // Test 4: fill to 4, blocked request, freeing a slot, push+pop, wrap and drain
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1,0,32'h300 + 4*k,0,1,0,0,          1,0,32'h300 + 4*k,1,0,0,0,0));
        vecs.push_back(mk(1,0,32'h310,0,1,0,0,                   0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,32'h310,0,1,1,32'h44,              0,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,32'h310,0,1,0,0,                   1,0,32'h310,1,0,0,0,0));
        vecs.push_back(mk(1,0,32'h314,0,1,1,32'h55,              0,0,0,0,0,1,0,0));
        vecs.push_back(mk(1,0,32'h314,0,1,1,32'h66,              1,0,32'h314,1,0,1,0,0));
        vecs.push_back(mk(1,0,32'h318,0,1,0,0,                   1,0,32'h318,1,0,0,0,0));
        vecs.push_back(mk(1,0,32'h31C,0,1,0,0,                   0,0,0,0,0,0,0,0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0,0,0,0,0,1,32'h70 + k,             0,0,0,0,0,1,0,0));
        // Test 5: orphan response sets the sticky error flag
        vecs.push_back(mk(0,0,0,0,0,1,32'h99,                    0,0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,1));

        // Reset with busy inputs: every handshake output must stay low
        reset = 1'b1;
        drive(1, 1, 32'hBFC0_0000, 32'h1000, 1, 1, 32'hDEAD);
        repeat (2) @(negedge clk);
        #1;
        check("rst sram_req",     bus.sram_req,     0);
        check("rst inst_addr_ok", bus.inst_addr_ok, 0);
        check("rst data_addr_ok", bus.data_addr_ok, 0);
        check("rst inst_data_ok", bus.inst_data_ok, 0);
        check("rst data_data_ok", bus.data_data_ok, 0);
        check("rst resp_err",     bus.resp_err,     0);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].ir, vecs[k].dr, vecs[k].ia, vecs[k].da,
                  vecs[k].aok, vecs[k].dok, vecs[k].rd);
            #1;
            check($sformatf("v%0d sram_req", k), bus.sram_req, vecs[k].e_sreq);
            if (vecs[k].e_sreq) begin
                check($sformatf("v%0d sram_addr", k), bus.sram_addr, vecs[k].e_saddr);
                check($sformatf("v%0d sram_wr", k), bus.sram_wr, vecs[k].e_gd);
                check($sformatf("v%0d sram_wdata", k), bus.sram_wdata,
                      vecs[k].e_gd ? D_WDATA : I_WDATA);
            end
            check($sformatf("v%0d inst_addr_ok", k), bus.inst_addr_ok, vecs[k].e_iaok);
            check($sformatf("v%0d data_addr_ok", k), bus.data_addr_ok, vecs[k].e_daok);
            check($sformatf("v%0d inst_data_ok", k), bus.inst_data_ok, vecs[k].e_idok);
            check($sformatf("v%0d data_data_ok", k), bus.data_data_ok, vecs[k].e_ddok);
            if (vecs[k].e_idok)
                check($sformatf("v%0d inst_rdata", k), bus.inst_rdata, vecs[k].rd);
            if (vecs[k].e_ddok)
                check($sformatf("v%0d data_rdata", k), bus.data_rdata, vecs[k].rd);
            check($sformatf("v%0d resp_err", k), bus.resp_err, vecs[k].e_err);
        end

        // Reset clears the sticky error flag
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post-rst resp_err", bus.resp_err, 0);

        // Sustained contention with addr_ok always high: four grants, then the FIFO is full
        for (int k = 0; k < 5; k++) begin
            logic [31:0] exp_addr;
            @(negedge clk);
            drive(1, 1, 32'hBFC0_0100, 32'h4000, 1, 0, 0);
            #1;
            if (k == 4) begin
                check("contend full sram_req", bus.sram_req, 0);
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_addr = (k % 2 == 0) ? 32'h4000 : 32'hBFC0_0100;
`else
                exp_addr = 32'h4000;
`endif
                check($sformatf("contend%0d sram_addr", k), bus.sram_addr, exp_addr);
                check($sformatf("contend%0d data_addr_ok", k), bus.data_addr_ok,
                      exp_addr == 32'h4000);
            end
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
